// File: rtl/timer_core_if.sv
// timer_core_if
//   Bundles the per-channel control/value fields exchanged between the timer
//   register block (master) and the counter engine timer_core (slave).
//   master: drives the i_* configuration fields, reads back o_* status.
//   slave : consumes the i_* fields, drives the o_* counts/pulses/flags.
interface timer_core_if;
    logic        i_cnt0_en;
    logic        i_cnt0_reload;
    logic        i_cnt0_count_up;
    logic [31:0] i_cnt0_load_value;
    logic [31:0] i_cnt0_compare_value;
    logic [31:0] o_cnt0_value;
    logic        o_cnt0_match;
    logic        o_cnt0_done;

    logic        i_cnt1_en;
    logic        i_cnt1_reload;
    logic        i_cnt1_count_up;
    logic [31:0] i_cnt1_load_value;
    logic [31:0] i_cnt1_compare_value;
    logic        i_cnt1_src;
    logic [31:0] o_cnt1_value;
    logic        o_cnt1_match;
    logic        o_cnt1_done;

    modport master (
        output i_cnt0_en, i_cnt0_reload, i_cnt0_count_up,
        output i_cnt0_load_value, i_cnt0_compare_value,
        input  o_cnt0_value, o_cnt0_match, o_cnt0_done,
        output i_cnt1_en, i_cnt1_reload, i_cnt1_count_up,
        output i_cnt1_load_value, i_cnt1_compare_value, i_cnt1_src,
        input  o_cnt1_value, o_cnt1_match, o_cnt1_done
    );

    modport slave (
        input  i_cnt0_en, i_cnt0_reload, i_cnt0_count_up,
        input  i_cnt0_load_value, i_cnt0_compare_value,
        output o_cnt0_value, o_cnt0_match, o_cnt0_done,
        input  i_cnt1_en, i_cnt1_reload, i_cnt1_count_up,
        input  i_cnt1_load_value, i_cnt1_compare_value, i_cnt1_src,
        output o_cnt1_value, o_cnt1_match, o_cnt1_done
    );
endinterface

// File: rtl/timer_core.sv
// timer_core
//   Two 32-bit counter channels with compare-match pulses, auto-reload and
//   done flags. Channel 1 can be cascaded to tick on channel 0 matches.
//   Ports:
//     clk - single clock
//     rst - synchronous, active-high reset
//     bus - timer_core_if.slave carrying all channel config and status
//   All outputs are registered.

// timer_channel: one counter channel; tick qualifies RUN-state counting.
module timer_channel (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        reload,
    input  logic        count_up,
    input  logic        tick,
    input  logic [31:0] load_value,
    input  logic [31:0] compare_value,
    output logic [31:0] value,
    output logic        match,
    output logic        done
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e      state_q;
    state_e      state_d;
    state_e      state_cur_s;
    logic        en_prev_q;
    logic [31:0] value_q;
    logic [31:0] value_d;
    logic        match_q;
    logic        match_d;
    logic        done_q;
    logic        done_d;
    logic        hit_s;

    assign hit_s = (value_q == compare_value);

    // Effective current state: the cycle in which en is seen rising while idle
    // is the LOAD cycle, so the load lands at that edge and counting starts
    // at the following one. en_prev_q resets to 1 so an en held high through
    // reset does not trigger a load until it is toggled.
    always_comb begin
        if ((state_q == ST_IDLE) && en && !en_prev_q) begin
            state_cur_s = ST_LOAD;
        end else begin
            state_cur_s = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            en_prev_q <= 1'b1;
            value_q   <= 32'd0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_prev_q <= en;
            value_q   <= value_d;
            match_q   <= match_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; en low wins over everything, including a match.
    always_comb begin
        state_d = state_cur_s;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_cur_s)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: state_d = ST_RUN;
                ST_RUN: begin
                    if (tick && hit_s && !reload) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output/datapath logic for value, match pulse and done flag.
    always_comb begin
        value_d = value_q;
        match_d = 1'b0;
        done_d  = done_q;
        if (!en) begin
            done_d = 1'b0;
        end else begin
            case (state_cur_s)
                ST_IDLE: done_d = 1'b0;
                ST_LOAD: begin
                    value_d = load_value;
                    done_d  = 1'b0;
                end
                ST_RUN: begin
                    if (tick) begin
                        if (hit_s) begin
                            match_d = 1'b1;
                            if (reload) begin
                                value_d = load_value;
                            end else begin
                                done_d = 1'b1;
                            end
                        end else if (count_up) begin
                            value_d = value_q + 32'd1;
                        end else begin
                            value_d = value_q - 32'd1;
                        end
                    end else begin
                        value_d = value_q;
                    end
                end
                ST_DONE: done_d = 1'b1;
                default: begin
                    value_d = value_q;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    assign value = value_q;
    assign match = match_q;
    assign done  = done_q;
endmodule

// timer_core: two channels, channel 1 optionally ticked by channel 0's
// registered match pulse.
module timer_core (
    input  logic         clk,
    input  logic         rst,
    timer_core_if.slave  bus
);
    logic [31:0] cnt0_value_s;
    logic        cnt0_match_s;
    logic        cnt0_done_s;
    logic [31:0] cnt1_value_s;
    logic        cnt1_match_s;
    logic        cnt1_done_s;
    logic        cnt1_tick_s;

    assign cnt1_tick_s = bus.i_cnt1_src ? cnt0_match_s : 1'b1;

    timer_channel u_ch0 (
        .clk           (clk),
        .rst           (rst),
        .en            (bus.i_cnt0_en),
        .reload        (bus.i_cnt0_reload),
        .count_up      (bus.i_cnt0_count_up),
        .tick          (1'b1),
        .load_value    (bus.i_cnt0_load_value),
        .compare_value (bus.i_cnt0_compare_value),
        .value         (cnt0_value_s),
        .match         (cnt0_match_s),
        .done          (cnt0_done_s)
    );

    timer_channel u_ch1 (
        .clk           (clk),
        .rst           (rst),
        .en            (bus.i_cnt1_en),
        .reload        (bus.i_cnt1_reload),
        .count_up      (bus.i_cnt1_count_up),
        .tick          (cnt1_tick_s),
        .load_value    (bus.i_cnt1_load_value),
        .compare_value (bus.i_cnt1_compare_value),
        .value         (cnt1_value_s),
        .match         (cnt1_match_s),
        .done          (cnt1_done_s)
    );

    assign bus.o_cnt0_value = cnt0_value_s;
    assign bus.o_cnt0_match = cnt0_match_s;
    assign bus.o_cnt0_done  = cnt0_done_s;
    assign bus.o_cnt1_value = cnt1_value_s;
    assign bus.o_cnt1_match = cnt1_match_s;
    assign bus.o_cnt1_done  = cnt1_done_s;
endmodule

// File: tb/tb_timer_core.sv
// tb_timer_core: randomized and directed checks of timer_core against a
// behavioural model of the two channels.
module tb_timer_core;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    timer_core_if bus ();

    timer_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 = idle, 1 = counting, 2 = finished.
    logic [31:0] m_val [2];
    logic        m_match [2];
    logic        m_done [2];
    logic        m_prev [2];
    int          m_mode [2];

    function automatic logic [67:0] dut_vec();
        return {bus.o_cnt0_value, bus.o_cnt0_match, bus.o_cnt0_done,
                bus.o_cnt1_value, bus.o_cnt1_match, bus.o_cnt1_done};
    endfunction

    function automatic logic [67:0] model_vec();
        return {m_val[0], m_match[0], m_done[0], m_val[1], m_match[1], m_done[1]};
    endfunction

    // Advance one clock: evaluate the model on the inputs present before the
    // edge, then commit after the edge.
    task automatic step();
        logic [31:0] nv [2];
        logic        nm [2];
        logic        nd [2];
        logic        ne [2];
        int          nmode [2];
        logic        en, rl, up, tk;
        logic [31:0] ld, cp;
        for (int c = 0; c < 2; c++) begin
            en = (c == 0) ? bus.i_cnt0_en : bus.i_cnt1_en;
            rl = (c == 0) ? bus.i_cnt0_reload : bus.i_cnt1_reload;
            up = (c == 0) ? bus.i_cnt0_count_up : bus.i_cnt1_count_up;
            ld = (c == 0) ? bus.i_cnt0_load_value : bus.i_cnt1_load_value;
            cp = (c == 0) ? bus.i_cnt0_compare_value : bus.i_cnt1_compare_value;
            tk = (c == 0) ? 1'b1 : (bus.i_cnt1_src ? m_match[0] : 1'b1);
            nv[c] = m_val[c];
            nm[c] = 1'b0;
            nd[c] = m_done[c];
            nmode[c] = m_mode[c];
            ne[c] = en;
            if (rst) begin
                nv[c] = 32'd0; nd[c] = 1'b0; nmode[c] = 0; ne[c] = 1'b1;
            end else if (!en) begin
                nd[c] = 1'b0; nmode[c] = 0;
            end else if (m_mode[c] == 0) begin
                if (!m_prev[c]) begin
                    nv[c] = ld; nmode[c] = 1;
                end
            end else if (m_mode[c] == 1 && tk) begin
                if (m_val[c] == cp) begin
                    nm[c] = 1'b1;
                    if (rl) nv[c] = ld;
                    else begin nd[c] = 1'b1; nmode[c] = 2; end
                end else begin
                    nv[c] = up ? m_val[c] + 32'd1 : m_val[c] - 32'd1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            m_val[c] = nv[c]; m_match[c] = nm[c]; m_done[c] = nd[c];
            m_mode[c] = nmode[c]; m_prev[c] = ne[c];
        end
    endtask

    task automatic cfg0(input logic up, input logic rl, input logic [31:0] ld, input logic [31:0] cp);
        bus.i_cnt0_count_up = up; bus.i_cnt0_reload = rl;
        bus.i_cnt0_load_value = ld; bus.i_cnt0_compare_value = cp;
    endtask

    task automatic cfg1(input logic up, input logic rl, input logic [31:0] ld, input logic [31:0] cp, input logic src);
        bus.i_cnt1_count_up = up; bus.i_cnt1_reload = rl;
        bus.i_cnt1_load_value = ld; bus.i_cnt1_compare_value = cp; bus.i_cnt1_src = src;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if (dut_vec() !== 68'd0) begin
            $display("FAIL reset_state: got %h want 0", dut_vec()); errors++;
        end
        rst = 1'b0;
        step();
        checks++;
        if (dut_vec() !== model_vec()) begin
            $display("FAIL reset_idle: got %h want %h", dut_vec(), model_vec()); errors++;
        end
    endtask

    task automatic test_up_reload();
        cfg0(1'b1, 1'b1, 32'd0, 32'd3);
        bus.i_cnt0_en = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            checks++;
            if (bus.o_cnt0_value !== 32'((k - 1) % 4) ||
                bus.o_cnt0_match !== ((k > 1) && ((k - 1) % 4 == 0)) ||
                bus.o_cnt0_done !== 1'b0 || dut_vec() !== model_vec()) begin
                $display("FAIL up_reload k=%0d: got v=%h m=%b d=%b want v=%h",
                         k, bus.o_cnt0_value, bus.o_cnt0_match, bus.o_cnt0_done, 32'((k - 1) % 4));
                errors++;
            end
        end
        bus.i_cnt0_en = 1'b0;
        step();
    endtask

    task automatic test_down_done();
        int mcount;
        mcount = 0;
        cfg0(1'b0, 1'b0, 32'd5, 32'd2);
        bus.i_cnt0_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (bus.o_cnt0_match) mcount++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL down_done k=%0d: got %h want %h", k, dut_vec(), model_vec()); errors++;
            end
        end
        checks++;
        if (mcount != 1 || bus.o_cnt0_value !== 32'd2 || bus.o_cnt0_done !== 1'b1) begin
            $display("FAIL down_done_final: got matches=%0d v=%h d=%b want 1/2/1",
                     mcount, bus.o_cnt0_value, bus.o_cnt0_done);
            errors++;
        end
        bus.i_cnt0_en = 1'b0;
        step();
        checks++;
        if (bus.o_cnt0_value !== 32'd2 || bus.o_cnt0_done !== 1'b0) begin
            $display("FAIL down_done_clear: got v=%h d=%b want 2/0", bus.o_cnt0_value, bus.o_cnt0_done);
            errors++;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seq [4];
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                cfg0(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd1);
                seq[0] = 32'hFFFF_FFFE; seq[1] = 32'hFFFF_FFFF; seq[2] = 32'd0; seq[3] = 32'd1;
            end else begin
                cfg0(1'b0, 1'b0, 32'd1, 32'hFFFF_FFFE);
                seq[0] = 32'd1; seq[1] = 32'd0; seq[2] = 32'hFFFF_FFFF; seq[3] = 32'hFFFF_FFFE;
            end
            bus.i_cnt0_en = 1'b1;
            for (int k = 0; k < 4; k++) begin
                step();
                checks++;
                if (bus.o_cnt0_value !== seq[k] || bus.o_cnt0_match !== 1'b0) begin
                    $display("FAIL wrap%0d k=%0d: got v=%h m=%b want v=%h m=0",
                             pass, k, bus.o_cnt0_value, bus.o_cnt0_match, seq[k]);
                    errors++;
                end
            end
            step();
            checks++;
            if (bus.o_cnt0_match !== 1'b1 || bus.o_cnt0_done !== 1'b1 || bus.o_cnt0_value !== seq[3]) begin
                $display("FAIL wrap%0d_match: got m=%b d=%b v=%h want 1/1/%h",
                         pass, bus.o_cnt0_match, bus.o_cnt0_done, bus.o_cnt0_value, seq[3]);
                errors++;
            end
            bus.i_cnt0_en = 1'b0;
            step();
        end
    endtask

    task automatic test_cascade();
        int last, m0, m1;
        last = -1; m0 = 0; m1 = 0;
        cfg0(1'b1, 1'b1, 32'd0, 32'd2);
        cfg1(1'b1, 1'b1, 32'd0, 32'd1, 1'b1);
        bus.i_cnt0_en = 1'b1; bus.i_cnt1_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.o_cnt0_match) m0++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL cascade k=%0d: got %h want %h", k, dut_vec(), model_vec()); errors++;
            end
            if (bus.o_cnt1_match) begin
                m1++;
                if (last >= 0) begin
                    checks++;
                    if (k - last != 6) begin
                        $display("FAIL cascade_period: got %0d want 6", k - last); errors++;
                    end
                end
                last = k;
            end
        end
        checks++;
        if (m1 < 5 || m0 / 2 != m1) begin
            $display("FAIL cascade_ratio: got ch0=%0d ch1=%0d want ch1=ch0/2", m0, m1); errors++;
        end
        bus.i_cnt0_en = 1'b0; bus.i_cnt1_en = 1'b0;
        bus.i_cnt1_src = 1'b0;
        step();
    endtask

    task automatic test_boundary();
        int n;
        cfg0(1'b1, 1'b1, 32'd0, 32'd5);
        bus.i_cnt0_en = 1'b1;
        n = 0;
        do begin step(); n++; end while (m_val[0] != 32'd5 && n < 20);
        bus.i_cnt0_en = 1'b0;
        step();
        checks++;
        if (n >= 20 || bus.o_cnt0_match !== 1'b0 || bus.o_cnt0_value !== 32'd5 || bus.o_cnt0_done !== 1'b0) begin
            $display("FAIL en_drop_at_match: got m=%b v=%h d=%b want 0/5/0",
                     bus.o_cnt0_match, bus.o_cnt0_value, bus.o_cnt0_done);
            errors++;
        end
        bus.i_cnt0_en = 1'b1;
        step();
        checks++;
        if (bus.o_cnt0_value !== 32'd0 || dut_vec() !== model_vec()) begin
            $display("FAIL reenable_load: got v=%h want 0", bus.o_cnt0_value); errors++;
        end
        bus.i_cnt0_en = 1'b0;
        step();
        cfg0(1'b1, 1'b0, 32'd0, 32'd10);
        bus.i_cnt0_en = 1'b1;
        n = 0;
        do begin step(); n++; end while (m_val[0] != 32'd6 && n < 20);
        bus.i_cnt0_compare_value = 32'd4;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (bus.o_cnt0_match !== 1'b0 || dut_vec() !== model_vec()) begin
                $display("FAIL cmp_change k=%0d: got m=%b v=%h want m=0 v=%h",
                         k, bus.o_cnt0_match, bus.o_cnt0_value, m_val[0]);
                errors++;
            end
        end
        checks++;
        if (bus.o_cnt0_value !== 32'd26) begin
            $display("FAIL cmp_change_final: got %h want 1a", bus.o_cnt0_value); errors++;
        end
        bus.i_cnt0_en = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        cfg1(1'b1, 1'b0, 32'd0, 32'd2, 1'b0);
        bus.i_cnt1_en = 1'b1;
        for (int k = 0; k < 6; k++) step();
        checks++;
        if (bus.o_cnt1_done !== 1'b1 || bus.o_cnt1_value !== 32'd2) begin
            $display("FAIL ch1_done: got d=%b v=%h want 1/2", bus.o_cnt1_done, bus.o_cnt1_value); errors++;
        end
        rst = 1'b1;
        step();
        checks++;
        if (dut_vec() !== 68'd0) begin
            $display("FAIL reset_mid: got %h want 0", dut_vec()); errors++;
        end
        rst = 1'b0;
        bus.i_cnt1_load_value = 32'd7;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus.o_cnt1_value !== 32'd0 || dut_vec() !== model_vec()) begin
                $display("FAIL no_load_after_rst k=%0d: got v=%h want 0", k, bus.o_cnt1_value); errors++;
            end
        end
        bus.i_cnt1_en = 1'b0;
        step();
        bus.i_cnt1_en = 1'b1;
        step();
        checks++;
        if (bus.o_cnt1_value !== 32'd7) begin
            $display("FAIL toggle_load: got %h want 7", bus.o_cnt1_value); errors++;
        end
        bus.i_cnt1_en = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) bus.i_cnt0_en = ~bus.i_cnt0_en;
            if ($urandom_range(0, 15) == 0) bus.i_cnt1_en = ~bus.i_cnt1_en;
            if ($urandom_range(0, 31) == 0)
                cfg0(1'($urandom), 1'($urandom), 32'($urandom_range(0, 12)), 32'($urandom_range(0, 12)));
            if ($urandom_range(0, 31) == 0)
                cfg1(1'($urandom), 1'($urandom), 32'($urandom_range(0, 6)),
                     32'($urandom_range(0, 6)), 1'($urandom));
            if ($urandom_range(0, 63) == 0) bus.i_cnt0_compare_value = 32'($urandom_range(0, 12));
            rst = ($urandom_range(0, 299) == 0);
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL random k=%0d: got %h want %h", k, dut_vec(), model_vec()); errors++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            m_val[c] = 32'd0; m_match[c] = 1'b0; m_done[c] = 1'b0; m_prev[c] = 1'b1; m_mode[c] = 0;
        end
        bus.i_cnt0_en = 1'b0; bus.i_cnt1_en = 1'b0;
        cfg0(1'b1, 1'b0, 32'd0, 32'd0);
        cfg1(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        test_reset();
        test_up_reload();
        test_down_done();
        test_wrap();
        test_cascade();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/timer_core.md
# timer_core

Counter engine for the two timer/counter channels. It takes the per-channel control and value fields from the AXI4-Lite timer register block and runs two 32-bit counters. It returns the live counts to that block for readback. It also produces compare-match pulses and done flags for the interrupt logic. Channel 1 can be cascaded so that it advances on channel 0 matches instead of on every clock.

## Interface
Parameters:
- none; all counters are fixed at 32 bits.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset, synchronous and active-high.
- i_cnt0_en  in  1  channel 0 enable.
- i_cnt0_reload  in  1  channel 0 auto-reload on match.
- i_cnt0_count_up  in  1  channel 0 direction; 1 counts up, 0 counts down.
- i_cnt0_load_value  in  32  channel 0 start/reload value.
- i_cnt0_compare_value  in  32  channel 0 match value.
- o_cnt0_value  out  32  channel 0 current count.
- o_cnt0_match  out  1  channel 0 one-cycle match pulse.
- o_cnt0_done  out  1  channel 0 stopped at match (no reload).
- i_cnt1_en, i_cnt1_reload, i_cnt1_count_up, i_cnt1_load_value, i_cnt1_compare_value  in  1/1/1/32/32  channel 1 equivalents of the channel 0 inputs.
- i_cnt1_src  in  1  channel 1 tick source; 0 = every clk, 1 = o_cnt0_match.
- o_cnt1_value  out  32  channel 1 current count.
- o_cnt1_match  out  1  channel 1 one-cycle match pulse.
- o_cnt1_done  out  1  channel 1 stopped at match.

## Operation
- Each channel is an independent state machine with states IDLE, LOAD, RUN and DONE. The channels are identical except for the tick source.
- IDLE: entered from reset and whenever en=0, from any state.
  - value holds; match=0; done=0.
  - A 0→1 transition of en goes to LOAD.
- LOAD: lasts one cycle.
  - value ← load_value.
  - Next state is RUN (or IDLE if en=0).
- RUN, on each tick (channel 0: every cycle; channel 1: every cycle if src=0, or a cycle with o_cnt0_match=1 if src=1):
  - If value == compare_value:
    - match ← 1 for one cycle.
    - If reload=1, value ← load_value and stay in RUN.
    - Otherwise value holds, done ← 1, and go to DONE.
  - Else value ← value+1 (count_up=1) or value−1 (count_up=0), modulo 2^32.
    - 0xFFFFFFFF+1 wraps to 0.
    - 0−1 wraps to 0xFFFFFFFF.
- RUN with no tick: value holds; match=0.
- DONE:
  - value holds at compare; done=1; no further match pulses.
  - Exits only via en=0, to IDLE, which clears done.
- Config changes while running:
  - compare_value and count_up are sampled on every tick and take effect immediately.
  - load_value is used at the next LOAD or reload.
  - A change of reload while in DONE has no effect.
- Cascade:
  - Channel 1 in src=1 uses the registered o_cnt0_match.
  - A channel 0 match in cycle N therefore advances channel 1 in cycle N+1.
  - A channel 0 reload/match cadence of P cycles gives channel 1 one tick per P cycles.
- Simultaneous events:
  - en falling beats match: the channel goes to IDLE and no match pulse is produced.
  - LOAD beats a tick: a tick arriving in the LOAD cycle is ignored.
- Reset mid-operation: all state returns to reset values on the next clk edge, whatever the state.

## Timing
- Reset values: o_cnt0_value=0, o_cnt1_value=0, all match=0, all done=0; both FSMs in IDLE.
- All outputs are registered; there are no combinational input-to-output paths.
- Cycle numbering:
  - en rises, sampled at edge 0.
  - LOAD occurs at edge 0; value=load_value is visible from cycle 1.
  - The first count change occurs at edge 1.
- Match latency: with value==compare visible in cycle k, match=1 and the new value are visible in cycle k+1.
- Reload period, counting up with no wrap: compare−load+1 cycles.
- Reload period, counting down: load−compare+1 cycles.
- en falling at edge N: from cycle N+1, state=IDLE, value frozen, match=0, done=0.

## Test plan
- Channel 0 up, load=0, compare=3, reload=1: value sequence 0,1,2,3,0,…; match pulses every 4 cycles, one cycle wide; done stays 0.
- Channel 0 down, load=5, compare=2, reload=0: value sequence 5,4,3,2; match pulses once; done=1 and value holds at 2 until en drops; en low clears done and value stays 2.
- Wrap: channel 0 up, load=0xFFFFFFFE, compare=1: value sequence FFFFFFFE, FFFFFFFF, 0, 1; match fires at 1. Repeat counting down from 1 with compare=0xFFFFFFFE.
- Cascade: channel 0 with load=0, compare=2, reload=1; channel 1 with src=1, up, load=0, compare=1, reload=1. Channel 1 increments one cycle after each channel 0 match; o_cnt1_match fires on every 2nd channel 0 match (period 6 cycles).
- Boundary events:
  - Drop en in the same cycle value==compare: no match pulse, IDLE.
  - Raise en again: LOAD reloads load_value.
  - Change compare from 10 to 4 while value=6, counting up: no match until wrap.
- Reset mid-run: assert rst while channel 1 is in DONE. The next cycle shows all outputs at 0; after rst is released, en held high produces no LOAD until it is toggled low then high.
